// File: rtl/pedc_window_sequencer.sv
// pedc_window_sequencer
// Walks a KxK stride-1 convolution window over an IMG_W x IMG_H feature map
// once per run request. Each issued tap yields a pixel address, a weight
// address and the PE accumulate controls. Done pulses once the last window's
// result has left the MAC pipe, and feeds the controller's Stop_Routine.
//
// Output timing: all outputs come straight from flops. A tap issued in cycle
// t (state RUN, Enable=1, Stall=0) shows Addr_Valid plus its addresses in
// cycle t+1. Addr_Valid is a pure strobe with no ready: the consumer must
// accept the addresses in every cycle Addr_Valid is high, and there is no
// back-pressure path other than Stall. Out_Valid for a window rises
// PIPE_LAT cycles after its last tap was issued.
//
// Debug state encoding on PEDC_SEQ_Dbg_State: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
module pedc_window_sequencer #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 3,
    parameter int ADDR_W   = 10,
    parameter int PIPE_LAT = 2,
    localparam int WGT_W   = (K > 1) ? $clog2(K * K) : 1
) (
    input  logic              PEDC_SEQ_Clk,
    input  logic              PEDC_SEQ_Reset,
    input  logic              PEDC_SEQ_Enable,
    input  logic              PEDC_SEQ_Stall,
    output logic [ADDR_W-1:0] PEDC_SEQ_Pix_Addr,
    output logic [WGT_W-1:0]  PEDC_SEQ_Wgt_Addr,
    output logic              PEDC_SEQ_Addr_Valid,
    output logic              PEDC_SEQ_Acc_Clear,
    output logic              PEDC_SEQ_Out_Valid,
    output logic              PEDC_SEQ_Done,
    output logic [1:0]        PEDC_SEQ_Dbg_State
);

    // Address arithmetic width: one guard bit over the pixel address.
    localparam int AW1 = ADDR_W + 1;
    // Number of window origins along each axis.
    localparam int NWC = IMG_W - K + 1;
    localparam int NWR = IMG_H - K + 1;
    // Counter widths, never narrower than one bit.
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int CW  = (NWC > 1) ? $clog2(NWC) : 1;
    localparam int RW  = (NWR > 1) ? $clog2(NWR) : 1;
    localparam int DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        kc_q, kc_d;
    logic [KW-1:0]        kr_q, kr_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 armed_q, armed_d;
    logic [PIPE_LAT-1:0]  pipe_q, pipe_d;

    logic [ADDR_W-1:0]    pix_d;
    logic [WGT_W-1:0]     wgt_d;
    logic                 av_d;
    logic                 clr_d;
    logic                 done_d;

    logic [AW1-1:0]       row_sum;
    logic [AW1-1:0]       col_sum;
    logic [AW1-1:0]       pix_full;
    logic [AW1-1:0]       wgt_full;

    logic                 last_kc;
    logic                 last_kr;
    logic                 last_col;
    logic                 last_row;
    logic                 last_tap;
    logic                 first_tap;

    // Addresses of the tap the counters currently point at.
    assign row_sum  = AW1'(row_q) + AW1'(kr_q);
    assign col_sum  = AW1'(col_q) + AW1'(kc_q);
    assign pix_full = row_sum * AW1'(IMG_W) + col_sum;
    assign wgt_full = AW1'(kr_q) * AW1'(K) + AW1'(kc_q);

    assign last_kc   = (kc_q == KW'(K - 1));
    assign last_kr   = (kr_q == KW'(K - 1));
    assign last_col  = (col_q == CW'(NWC - 1));
    assign last_row  = (row_q == RW'(NWR - 1));
    assign last_tap  = last_kc && last_kr;
    assign first_tap = (kc_q == '0) && (kr_q == '0);

    assign PEDC_SEQ_Out_Valid = pipe_q[PIPE_LAT-1];
    assign PEDC_SEQ_Dbg_State = state_q;

    // Next-state, counter advance and registered-output values.
    always_comb begin
        state_d = state_q;
        kc_d    = kc_q;
        kr_d    = kr_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        armed_d = armed_q | ~PEDC_SEQ_Enable;
        pipe_d  = pipe_q << 1;
        pix_d   = PEDC_SEQ_Pix_Addr;
        wgt_d   = PEDC_SEQ_Wgt_Addr;
        av_d    = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (PEDC_SEQ_Enable && armed_q) begin
                    state_d = S_RUN;
                    kc_d    = '0;
                    kr_d    = '0;
                    col_d   = '0;
                    row_d   = '0;
                    drain_d = '0;
                    armed_d = 1'b0;
                end
            end

            S_RUN: begin
                if (!PEDC_SEQ_Enable) begin
                    // Abort: drop everything, including results in flight.
                    state_d = S_IDLE;
                    kc_d    = '0;
                    kr_d    = '0;
                    col_d   = '0;
                    row_d   = '0;
                    pipe_d  = '0;
                end else if (!PEDC_SEQ_Stall) begin
                    av_d   = 1'b1;
                    clr_d  = first_tap;
                    pix_d  = ADDR_W'(pix_full);
                    wgt_d  = WGT_W'(wgt_full);
                    pipe_d = (pipe_q << 1) | PIPE_LAT'(last_tap);
                    // kc fastest, then kr, then col, then row.
                    if (!last_kc) begin
                        kc_d = kc_q + 1'b1;
                    end else begin
                        kc_d = '0;
                        if (!last_kr) begin
                            kr_d = kr_q + 1'b1;
                        end else begin
                            kr_d = '0;
                            if (!last_col) begin
                                col_d = col_q + 1'b1;
                            end else begin
                                col_d = '0;
                                if (!last_row) begin
                                    row_d = row_q + 1'b1;
                                end else begin
                                    row_d   = '0;
                                    state_d = S_DRAIN;
                                    drain_d = '0;
                                end
                            end
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (!PEDC_SEQ_Enable) begin
                    state_d = S_IDLE;
                    drain_d = '0;
                    pipe_d  = '0;
                end else if (drain_q == DW'(PIPE_LAT - 1)) begin
                    state_d = S_DONE;
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge PEDC_SEQ_Clk) begin
        if (PEDC_SEQ_Reset) begin
            state_q             <= S_IDLE;
            kc_q                <= '0;
            kr_q                <= '0;
            col_q               <= '0;
            row_q               <= '0;
            drain_q             <= '0;
            armed_q             <= 1'b1;
            pipe_q              <= '0;
            PEDC_SEQ_Pix_Addr   <= '0;
            PEDC_SEQ_Wgt_Addr   <= '0;
            PEDC_SEQ_Addr_Valid <= 1'b0;
            PEDC_SEQ_Acc_Clear  <= 1'b0;
            PEDC_SEQ_Done       <= 1'b0;
        end else begin
            state_q             <= state_d;
            kc_q                <= kc_d;
            kr_q                <= kr_d;
            col_q               <= col_d;
            row_q               <= row_d;
            drain_q             <= drain_d;
            armed_q             <= armed_d;
            pipe_q              <= pipe_d;
            PEDC_SEQ_Pix_Addr   <= pix_d;
            PEDC_SEQ_Wgt_Addr   <= wgt_d;
            PEDC_SEQ_Addr_Valid <= av_d;
            PEDC_SEQ_Acc_Clear  <= clr_d;
            PEDC_SEQ_Done       <= done_d;
        end
    end

endmodule

// File: tb/tb_pedc_window_sequencer.sv
// Bench for pedc_window_sequencer: directed scenarios plus randomized
// Enable/Stall traffic, checked against a tap-index reference model.
module tb_pedc_window_sequencer;

    localparam int IMG_W    = 5;
    localparam int IMG_H    = 4;
    localparam int K        = 3;
    localparam int ADDR_W   = 10;
    localparam int PIPE_LAT = 2;
    localparam int NWC      = IMG_W - K + 1;
    localparam int NWR      = IMG_H - K + 1;
    localparam int TPW      = K * K;
    localparam int NTAPS    = NWC * NWR * TPW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, enable, stall;
    logic [ADDR_W-1:0] pix;
    logic [3:0]        wgt;
    logic              av, clr, ov, done;
    logic [1:0]        dbg;

    logic              k1_reset, k1_enable, k1_stall;
    logic [ADDR_W-1:0] k1_pix;
    logic [0:0]        k1_wgt;
    logic              k1_av, k1_clr, k1_ov, k1_done;
    logic [1:0]        k1_dbg;

    pedc_window_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
    ) u_dut (
        .PEDC_SEQ_Clk(clk), .PEDC_SEQ_Reset(reset), .PEDC_SEQ_Enable(enable),
        .PEDC_SEQ_Stall(stall), .PEDC_SEQ_Pix_Addr(pix), .PEDC_SEQ_Wgt_Addr(wgt),
        .PEDC_SEQ_Addr_Valid(av), .PEDC_SEQ_Acc_Clear(clr), .PEDC_SEQ_Out_Valid(ov),
        .PEDC_SEQ_Done(done), .PEDC_SEQ_Dbg_State(dbg)
    );

    pedc_window_sequencer #(
        .IMG_W(2), .IMG_H(2), .K(1), .ADDR_W(ADDR_W), .PIPE_LAT(1)
    ) u_dut_k1 (
        .PEDC_SEQ_Clk(clk), .PEDC_SEQ_Reset(k1_reset), .PEDC_SEQ_Enable(k1_enable),
        .PEDC_SEQ_Stall(k1_stall), .PEDC_SEQ_Pix_Addr(k1_pix), .PEDC_SEQ_Wgt_Addr(k1_wgt),
        .PEDC_SEQ_Addr_Valid(k1_av), .PEDC_SEQ_Acc_Clear(k1_clr), .PEDC_SEQ_Out_Valid(k1_ov),
        .PEDC_SEQ_Done(k1_done), .PEDC_SEQ_Dbg_State(k1_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 running, 2 draining, 3 done-pulse.
    int  m_phase, m_tap, m_drain, m_armed;
    int  ov_q[$];           // edge numbers at which a window result appears
    logic e_av, e_clr, e_done, e_ov;
    logic [31:0] e_pix, e_wgt;
    int  edge_idx  = 0;
    int  run_start = -1000;

    task automatic model_abort();
        m_phase = 0;
        m_tap   = 0;
        ov_q.delete();
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic st);
        int w, i;
        e_av = 0; e_clr = 0; e_done = 0; e_ov = 0;
        if (rst) begin
            m_phase = 0; m_tap = 0; m_drain = 0; m_armed = 1;
            ov_q.delete();
            e_pix = 0; e_wgt = 0;
            return;
        end
        case (m_phase)
            0: if (en && m_armed != 0) begin
                m_phase = 1; m_tap = 0; m_armed = 0; run_start = edge_idx;
            end
            1: begin
                if (!en) model_abort();
                else if (!st) begin
                    w = m_tap / TPW;
                    i = m_tap % TPW;
                    e_pix = ((w / NWC) + (i / K)) * IMG_W + (w % NWC) + (i % K);
                    e_wgt = i;
                    e_av  = 1;
                    e_clr = (i == 0);
                    if (i == TPW - 1) ov_q.push_back(edge_idx + PIPE_LAT - 1);
                    m_tap++;
                    if (m_tap == NTAPS) begin
                        m_phase = 2; m_drain = PIPE_LAT;
                    end
                end
            end
            2: begin
                if (!en) model_abort();
                else begin
                    m_drain--;
                    if (m_drain == 0) begin
                        m_phase = 3; e_done = 1;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        if (!en) m_armed = 1;
        if (ov_q.size() > 0 && ov_q[0] == edge_idx) begin
            e_ov = 1;
            void'(ov_q.pop_front());
        end
    endtask

    // ---------------- statistics for directed checks ----------------
    int n_av, n_clr, n_ov, done_at;
    logic [31:0] pix_log[$];

    task automatic clear_stats();
        n_av = 0; n_clr = 0; n_ov = 0; done_at = -1;
        pix_log.delete();
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input logic st);
        reset  = rst;
        enable = en;
        stall  = st;
        @(posedge clk);
        edge_idx++;
        model_edge(rst, en, st);
        #1;
        check("addr_valid", 32'(av), 32'(e_av));
        check("acc_clear", 32'(clr), 32'(e_clr));
        check("out_valid", 32'(ov), 32'(e_ov));
        check("done", 32'(done), 32'(e_done));
        if (rst || e_av) begin
            check("pix_addr", 32'(pix), e_pix);
            check("wgt_addr", 32'(wgt), e_wgt);
        end
        if (av) begin
            n_av++;
            pix_log.push_back(32'(pix));
        end
        if (clr)  n_clr++;
        if (ov)   n_ov++;
        if (done) done_at = edge_idx - run_start;
    endtask

    function automatic int run_cycle();
        return edge_idx - run_start;
    endfunction

    logic [31:0] pix_seq[10];

    initial begin
        pix_seq = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 1};
        reset = 1; enable = 1; stall = 0;
        k1_reset = 1; k1_enable = 0; k1_stall = 0;
        clear_stats();

        // Reset held with Enable high: every output stays low.
        repeat (3) step(1, 1, 0);
        check("reset_dbg_state", 32'(dbg), 0);

        // Full run without stalls; first edge after reset enters RUN.
        clear_stats();
        step(0, 1, 0);
        check("run_entry_state", 32'(dbg), 1);
        repeat (60) step(0, 1, 0);
        check("t2_addr_valid_cnt", n_av, 54);
        check("t2_acc_clear_cnt", n_clr, 6);
        check("t2_out_valid_cnt", n_ov, 6);
        check("t2_done_cycle", done_at, 56);
        for (int i = 0; i < 10; i++)
            check("t2_pix_seq", (pix_log.size() > i) ? pix_log[i] : 32'hFFFF_FFFF, pix_seq[i]);

        // Enable still high after Done: no restart.
        clear_stats();
        repeat (10) step(0, 1, 0);
        check("t5_no_rerun", n_av, 0);

        // Drop Enable one cycle, rerun with Stall on RUN cycles 4-6.
        step(0, 0, 0);
        run_start = -1000;
        clear_stats();
        repeat (70) step(0, 1, (run_cycle() >= 4 && run_cycle() <= 6));
        check("t3_addr_valid_cnt", n_av, 54);
        check("t3_out_valid_cnt", n_ov, 6);
        check("t3_done_cycle", done_at, 59);

        // Abort on RUN cycle 20.
        step(0, 0, 0);
        run_start = -1000;
        clear_stats();
        for (int i = 0; i < 22; i++) step(0, (run_cycle() != 20), 0);
        check("t4_abort_state", 32'(dbg), 0);
        check("t4_out_valid_cnt", n_ov, 2);
        check("t4_no_done", done_at, -1);
        clear_stats();
        repeat (5) step(0, 1, 0);
        check("t4_restart_pix", (pix_log.size() > 0) ? pix_log[0] : 32'hFFFF_FFFF, 0);

        // Randomized Enable/Stall traffic.
        clear_stats();
        for (int i = 0; i < 3000; i++)
            step(0, ($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0));

        // K=1, 2x2 map, PIPE_LAT=1.
        enable = 0;
        check("k1_reset_av", 32'(k1_av), 0);
        check("k1_reset_done", 32'(k1_done), 0);
        k1_reset  = 0;
        k1_enable = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("k1_addr_valid", 32'(k1_av), 32'(c >= 1 && c <= 4));
            check("k1_acc_clear", 32'(k1_clr), 32'(c >= 1 && c <= 4));
            check("k1_out_valid", 32'(k1_ov), 32'(c >= 1 && c <= 4));
            check("k1_done", 32'(k1_done), 32'(c == 5));
            if (c >= 1 && c <= 4) begin
                check("k1_pix_addr", 32'(k1_pix), c - 1);
                check("k1_wgt_addr", 32'(k1_wgt), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
